// File: rtl/ecc_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helper for the NAND page ECC controller.
package ecc_pkg;

    localparam int         PAGE_BYTES  = 512;
    localparam int         SPARE_BYTES = 16;
    localparam int         BLK_BYTES   = 128;
    localparam int         NUM_BLKS    = PAGE_BYTES / BLK_BYTES;
    localparam logic [8:0] GF_POLY     = 9'h11D;

    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;
    localparam int STAT_CORR   = 2;
    localparam int STAT_UNCORR = 3;

    typedef enum logic [2:0] {
        IDLE,
        ENC_DATA,
        ENC_SPARE,
        DEC_RX,
        DEC_SEARCH,
        DEC_RD,
        DEC_WR,
        DONE
    } state_t;

    // Multiply by alpha (x) modulo the field polynomial.
    function automatic logic [7:0] mul_alpha(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY[7:0] : 8'h00);
    endfunction

endpackage

// File: rtl/ecc_blk_accum.sv
// Per-block check-byte accumulator: C0 is the byte parity, C1 the Horner sum in alpha.
module ecc_blk_accum
    import ecc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic [7:0] i_data,
    output logic [7:0] o_c0,
    output logic [7:0] o_c1
);

    logic [7:0] r_c0;
    logic [7:0] r_c1;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_c0 <= 8'h00;
            r_c1 <= 8'h00;
        end else if (i_en) begin
            r_c0 <= r_c0 ^ i_data;
            r_c1 <= mul_alpha(r_c1) ^ i_data;
        end
    end

    assign o_c0 = r_c0;
    assign o_c1 = r_c1;

endmodule

// File: rtl/ecc_page_ctrl.sv
// Page ECC controller: encodes SRAM pages to flash with spare check bytes, and decodes
// flash pages into SRAM correcting up to one byte per 128-byte block in place.
module ecc_page_ctrl
    import ecc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       encoding,
    output logic [7:0] sramDi,
    input  logic [7:0] sramDo,
    output logic [8:0] sramAdrs,
    output logic       sramEnable,
    output logic       sramWE,
    output logic [7:0] flashDi,
    output logic       flashDataValid,
    input  logic [7:0] flashDo,
    output logic [3:0] status,
    output state_t     o_dbg_state
);

    state_t     r_state;
    logic [9:0] r_cnt;
    logic [1:0] r_blk;
    logic [6:0] r_k;
    logic [7:0] r_t;
    logic       r_rd_wait;
    logic [7:0] r_s0 [NUM_BLKS];
    logic [7:0] r_s1 [NUM_BLKS];

    logic [7:0] r_sram_di;
    logic [8:0] r_sram_adrs;
    logic       r_sram_cen;
    logic       r_sram_we;
    logic [7:0] r_flash_di;
    logic       r_flash_vld;
    logic [3:0] r_status;

    logic       w_start_ok;
    logic       w_acc_en;
    logic [8:0] w_acc_idx;
    logic [7:0] w_acc_data;
    logic [7:0] w_c0 [NUM_BLKS];
    logic [7:0] w_c1 [NUM_BLKS];
    logic [3:0] w_spare_sel;
    logic [7:0] w_spare_byte;
    logic [2:0] w_rx_sel;
    logic [7:0] w_s0_cur;
    logic [7:0] w_s1_cur;
    logic       w_clean;
    logic       w_one_zero;
    logic       w_hit;
    logic       w_exhaust;
    logic       w_blk_end;

    assign w_start_ok = start && (r_state == IDLE || r_state == DONE);

    // r_cnt counts edges since the start edge; encode data lags its address by two edges.
    always_comb begin
        w_acc_en   = 1'b0;
        w_acc_idx  = 9'd0;
        w_acc_data = 8'h00;
        if (r_state == ENC_DATA && r_cnt >= 10'd2) begin
            w_acc_en   = 1'b1;
            w_acc_idx  = r_cnt[8:0] - 9'd2;
            w_acc_data = sramDo;
        end else if (r_state == DEC_RX && r_cnt <= 10'd512) begin
            w_acc_en   = 1'b1;
            w_acc_idx  = r_cnt[8:0] - 9'd1;
            w_acc_data = flashDo;
        end
    end

    for (genvar b = 0; b < NUM_BLKS; b++) begin : g_acc
        ecc_blk_accum u_acc (
            .clk    (clk),
            .reset  (reset),
            .i_clr  (w_start_ok),
            .i_en   (w_acc_en && (w_acc_idx[8:7] == 2'(b))),
            .i_data (w_acc_data),
            .o_c0   (w_c0[b]),
            .o_c1   (w_c1[b])
        );
    end

    assign w_spare_sel  = r_cnt[3:0] - 4'd2;
    assign w_spare_byte = w_spare_sel[3] ? 8'hFF :
                          (w_spare_sel[0] ? w_c1[w_spare_sel[2:1]] : w_c0[w_spare_sel[2:1]]);
    assign w_rx_sel     = r_cnt[2:0] - 3'd1;

    assign w_s0_cur   = r_s0[r_blk];
    assign w_s1_cur   = r_s1[r_blk];
    assign w_clean    = (w_s0_cur == 8'h00) && (w_s1_cur == 8'h00);
    assign w_one_zero = (w_s0_cur == 8'h00) ^ (w_s1_cur == 8'h00);
    assign w_hit      = (r_t == w_s1_cur);
    assign w_exhaust  = (r_k == 7'd127);
    assign w_blk_end  = (r_state == DEC_SEARCH &&
                         (w_clean || w_one_zero || (!w_hit && w_exhaust))) ||
                        (r_state == DEC_WR);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= 10'd0;
            r_blk       <= 2'd0;
            r_k         <= 7'd0;
            r_t         <= 8'h00;
            r_rd_wait   <= 1'b0;
            r_sram_di   <= 8'h00;
            r_sram_adrs <= 9'd0;
            r_sram_cen  <= 1'b1;
            r_sram_we   <= 1'b1;
            r_flash_di  <= 8'h00;
            r_flash_vld <= 1'b0;
            r_status    <= 4'b0000;
            for (int b = 0; b < NUM_BLKS; b++) begin
                r_s0[b] <= 8'h00;
                r_s1[b] <= 8'h00;
            end
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_status <= 4'b0001;
                        r_cnt    <= 10'd1;
                        r_blk    <= 2'd0;
                        if (encoding) begin
                            r_state     <= ENC_DATA;
                            r_sram_adrs <= 9'd0;
                            r_sram_cen  <= 1'b0;
                            r_sram_we   <= 1'b1;
                        end else begin
                            r_state <= DEC_RX;
                        end
                    end
                end
                ENC_DATA: begin
                    r_cnt <= r_cnt + 10'd1;
                    if (r_cnt <= 10'd511) begin
                        r_sram_adrs <= r_cnt[8:0];
                    end else begin
                        r_sram_cen <= 1'b1;
                    end
                    if (r_cnt >= 10'd2) begin
                        r_flash_di  <= sramDo;
                        r_flash_vld <= 1'b1;
                    end
                    if (r_cnt == 10'd513) begin
                        r_state <= ENC_SPARE;
                    end
                end
                ENC_SPARE: begin
                    r_cnt <= r_cnt + 10'd1;
                    if (r_cnt == 10'd530) begin
                        r_flash_vld <= 1'b0;
                        r_status    <= 4'b0010;
                        r_state     <= DONE;
                    end else begin
                        r_flash_di <= w_spare_byte;
                    end
                end
                DEC_RX: begin
                    r_cnt <= r_cnt + 10'd1;
                    if (r_cnt <= 10'd512) begin
                        r_sram_adrs <= w_acc_idx;
                        r_sram_di   <= flashDo;
                        r_sram_cen  <= 1'b0;
                        r_sram_we   <= 1'b0;
                    end else begin
                        r_sram_cen <= 1'b1;
                        r_sram_we  <= 1'b1;
                        if (r_cnt <= 10'd520) begin
                            if (w_rx_sel[0]) begin
                                r_s1[w_rx_sel[2:1]] <= w_c1[w_rx_sel[2:1]] ^ flashDo;
                            end else begin
                                r_s0[w_rx_sel[2:1]] <= w_c0[w_rx_sel[2:1]] ^ flashDo;
                            end
                        end
                    end
                    if (r_cnt == 10'd528) begin
                        r_state <= DEC_SEARCH;
                        r_blk   <= 2'd0;
                        r_k     <= 7'd0;
                        r_t     <= r_s0[0];
                    end
                end
                DEC_SEARCH: begin
                    // t walks S0*alpha^k; a hit at step k places the error at j = 127-k.
                    if (!w_clean && !w_one_zero) begin
                        if (w_hit) begin
                            r_sram_adrs <= {r_blk, 7'd127 - r_k};
                            r_sram_cen  <= 1'b0;
                            r_sram_we   <= 1'b1;
                            r_rd_wait   <= 1'b1;
                            r_state     <= DEC_RD;
                        end else if (!w_exhaust) begin
                            r_t <= mul_alpha(r_t);
                            r_k <= r_k + 7'd1;
                        end
                    end
                end
                DEC_RD: begin
                    if (r_rd_wait) begin
                        r_rd_wait  <= 1'b0;
                        r_sram_cen <= 1'b1;
                    end else begin
                        r_sram_di  <= sramDo ^ w_s0_cur;
                        r_sram_cen <= 1'b0;
                        r_sram_we  <= 1'b0;
                        r_state    <= DEC_WR;
                    end
                end
                DEC_WR: begin
                    r_sram_cen <= 1'b1;
                    r_sram_we  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase

            if (w_blk_end) begin
                if (r_state == DEC_WR || w_one_zero) begin
                    r_status[STAT_CORR] <= 1'b1;
                end
                if (r_state == DEC_SEARCH && !w_clean && !w_one_zero) begin
                    r_status[STAT_UNCORR] <= 1'b1;
                end
                if (r_blk == 2'(NUM_BLKS - 1)) begin
                    r_status[STAT_BUSY] <= 1'b0;
                    r_status[STAT_DONE] <= 1'b1;
                    r_state             <= DONE;
                end else begin
                    r_blk   <= r_blk + 2'd1;
                    r_k     <= 7'd0;
                    r_t     <= r_s0[r_blk + 2'd1];
                    r_state <= DEC_SEARCH;
                end
            end
        end
    end

    assign sramDi         = r_sram_di;
    assign sramAdrs       = r_sram_adrs;
    assign sramEnable     = r_sram_cen;
    assign sramWE         = r_sram_we;
    assign flashDi        = r_flash_di;
    assign flashDataValid = r_flash_vld;
    assign status         = r_status;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_ecc_page_ctrl.sv
// Bench for ecc_page_ctrl: SRAM model, flash-side driver, GF(2^8) reference model,
// and a monitor that scores flash bytes and completion status against expected queues.
module tb_ecc_page_ctrl;
    import ecc_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       encoding;
    logic [7:0] sramDi;
    logic [7:0] sramDo;
    logic [8:0] sramAdrs;
    logic       sramEnable;
    logic       sramWE;
    logic [7:0] flashDi;
    logic       flashDataValid;
    logic [7:0] flashDo;
    logic [3:0] status;
    state_t     dbg_state;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q [$];
    logic [3:0] stat_q [$];

    logic [7:0] mem [0:511];
    logic [7:0] sram_q = 8'h00;
    logic [7:0] ref_data [0:511];
    logic [7:0] page [0:527];
    logic [7:0] rx [0:527];
    logic [7:0] exp_mem [0:511];
    logic [7:0] apow [0:254];
    logic [7:0] cap [0:527];
    int         cap_idx = 0;
    logic       exp_unc;
    logic       exp_corr;
    int         run_len = 0;
    logic       prev_vld = 1'b0;
    logic       prev_done = 1'b0;

    always #5 clk = ~clk;

    ecc_page_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .encoding       (encoding),
        .sramDi         (sramDi),
        .sramDo         (sramDo),
        .sramAdrs       (sramAdrs),
        .sramEnable     (sramEnable),
        .sramWE         (sramWE),
        .flashDi        (flashDi),
        .flashDataValid (flashDataValid),
        .flashDo        (flashDo),
        .status         (status),
        .o_dbg_state    (dbg_state)
    );

    // Synchronous 512x8 SRAM: Q is registered and appears the cycle after the address.
    always @(posedge clk) begin
        if (!sramEnable) begin
            if (!sramWE) mem[sramAdrs] <= sramDi;
            else         sram_q <= mem[sramAdrs];
        end
    end
    assign sramDo = sram_q;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Carry-less product followed by reduction modulo x^8+x^4+x^3+x^2+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'(GF_POLY) << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [15:0] blk_checks(input int b, input logic use_rx);
        logic [7:0] c0;
        logic [7:0] c1;
        logic [7:0] d;
        c0 = 8'h00;
        c1 = 8'h00;
        for (int i = 0; i < 128; i++) begin
            d  = use_rx ? rx[b*128 + i] : ref_data[b*128 + i];
            c0 = c0 ^ d;
            c1 = c1 ^ gf_mul(d, apow[127 - i]);
        end
        return {c1, c0};
    endfunction

    task automatic model_encode();
        logic [15:0] c;
        for (int i = 0; i < 512; i++) page[i] = ref_data[i];
        for (int b = 0; b < 4; b++) begin
            c = blk_checks(b, 1'b0);
            page[512 + 2*b] = c[7:0];
            page[513 + 2*b] = c[15:8];
        end
        for (int i = 520; i < 528; i++) page[i] = 8'hFF;
    endtask

    task automatic model_decode();
        logic [15:0] c;
        logic [7:0]  s0;
        logic [7:0]  s1;
        logic        found;
        exp_corr = 1'b0;
        exp_unc  = 1'b0;
        for (int i = 0; i < 512; i++) exp_mem[i] = rx[i];
        for (int b = 0; b < 4; b++) begin
            c  = blk_checks(b, 1'b1);
            s0 = c[7:0] ^ rx[512 + 2*b];
            s1 = c[15:8] ^ rx[513 + 2*b];
            if (s0 == 8'h00 && s1 == 8'h00) begin
                found = 1'b0;
            end else if (s0 == 8'h00 || s1 == 8'h00) begin
                exp_corr = 1'b1;
            end else begin
                found = 1'b0;
                for (int j = 0; j < 128; j++) begin
                    if (!found && gf_mul(s0, apow[127 - j]) == s1) begin
                        exp_mem[b*128 + j] = exp_mem[b*128 + j] ^ s0;
                        found = 1'b1;
                    end
                end
                if (found) exp_corr = 1'b1;
                else       exp_unc  = 1'b1;
            end
        end
    endtask

    // Monitor: score every valid flash byte and every completion against the queues.
    always @(negedge clk) begin
        if (reset) begin
            run_len   = 0;
            prev_vld  = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (flashDataValid) begin
                run_len++;
                if (cap_idx < 528) cap[cap_idx] = flashDi;
                cap_idx++;
                if (exp_q.size() == 0) chk("flash_unexpected_byte", 32'(flashDi), 32'hFFFF_FFFF);
                else                   chk("flash_byte", 32'(flashDi), 32'(exp_q.pop_front()));
            end else if (prev_vld) begin
                chk("flash_run_len", 32'(run_len), 32'd528);
                run_len = 0;
            end
            if (status[STAT_DONE] && !prev_done) begin
                if (stat_q.size() == 0) chk("status_unexpected_done", 32'(status), 32'hFFFF_FFFF);
                else                    chk("status_at_done", 32'(status), 32'(stat_q.pop_front()));
            end
            prev_vld  = flashDataValid;
            prev_done = status[STAT_DONE];
        end
    end

    task automatic check_idle(input string nm);
        chk({nm, "_valid"}, 32'(flashDataValid), 32'd0);
        chk({nm, "_status"}, 32'(status), 32'd0);
        chk({nm, "_state"}, 32'(dbg_state), 32'(IDLE));
        chk({nm, "_cen"}, 32'(sramEnable), 32'd1);
        chk({nm, "_wen"}, 32'(sramWE), 32'd1);
        chk({nm, "_adrs"}, 32'(sramAdrs), 32'd0);
        chk({nm, "_flashdi"}, 32'(flashDi), 32'd0);
    endtask

    task automatic pulse_start(input logic enc);
        @(negedge clk);
        start    = 1'b1;
        encoding = enc;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", 32'(status), 32'h1);
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!status[STAT_DONE] && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, "_done_within_budget"}, 32'(status[STAT_DONE]), 32'd1);
        @(negedge clk);
        #1;
    endtask

    task automatic start_encode();
        int lat;
        for (int i = 0; i < 512; i++) mem[i] = ref_data[i];
        model_encode();
        for (int i = 0; i < 528; i++) exp_q.push_back(page[i]);
        stat_q.push_back(4'b0010);
        cap_idx = 0;
        pulse_start(1'b1);
        lat = 0;
        while (!flashDataValid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("enc_first_valid_latency", 32'(lat), 32'd2);
    endtask

    task automatic run_decode(input string nm);
        int nmis;
        int first;
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        model_decode();
        stat_q.push_back({exp_unc, exp_corr, 2'b10});
        pulse_start(1'b0);
        for (int k = 0; k < 528; k++) begin
            flashDo = rx[k];
            @(posedge clk);
            #1;
        end
        flashDo = 8'($urandom);
        wait_done(nm);
        nmis  = 0;
        first = -1;
        for (int i = 0; i < 512; i++) begin
            if (mem[i] !== exp_mem[i]) begin
                nmis++;
                if (first < 0) first = i;
            end
        end
        if (nmis != 0) $display("note %s: first differing SRAM address %0d", nm, first);
        chk({nm, "_sram_mismatch_count"}, 32'(nmis), 32'd0);
    endtask

    initial begin
        int p1;
        int p2;
        apow[0] = 8'h01;
        for (int i = 1; i < 255; i++) apow[i] = gf_mul(apow[i-1], 8'h02);

        reset    = 1'b1;
        start    = 1'b0;
        encoding = 1'b0;
        flashDo  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        reset = 1'b0;

        // Directed encode: ramp then inverted ramp.
        for (int i = 0; i < 512; i++) ref_data[i] = (i < 256) ? 8'(i) : ~8'(i);
        start_encode();
        wait_done("enc0");
        for (int b = 0; b < 4; b++) chk("enc0_c0_zero", 32'(cap[512 + 2*b]), 32'h00);
        for (int i = 520; i < 528; i++) chk("enc0_spare_ff", 32'(cap[i]), 32'hFF);

        // Clean decode.
        for (int i = 0; i < 528; i++) rx[i] = page[i];
        run_decode("dec_clean");
        chk("dec_clean_flags", 32'(status[3:2]), 32'd0);

        // Single bad data byte in block 1.
        for (int i = 0; i < 528; i++) rx[i] = page[i];
        rx[171] = 8'h00;
        run_decode("dec171");
        chk("dec171_restored", 32'(mem[171]), 32'hAB);
        chk("dec171_corrected", 32'(status[STAT_CORR]), 32'd1);

        // Two bad bytes in block 0, chosen so the pattern is not a valid single error.
        for (int i = 0; i < 528; i++) rx[i] = page[i];
        rx[10] = page[10] ^ 8'h5A;
        for (int e = 1; e < 256; e++) begin
            rx[20] = page[20] ^ 8'(e);
            model_decode();
            if (exp_unc) break;
        end
        run_decode("dec_double");
        chk("dec_double_uncorr", 32'(status[STAT_UNCORR]), 32'd1);
        chk("dec_double_b10", 32'(mem[10]), 32'(rx[10]));
        chk("dec_double_b20", 32'(mem[20]), 32'(rx[20]));

        // Corrupted spare byte only.
        for (int i = 0; i < 528; i++) rx[i] = page[i];
        rx[512] = page[512] ^ 8'h33;
        run_decode("dec_spare");
        chk("dec_spare_corrected", 32'(status[STAT_CORR]), 32'd1);
        for (int i = 0; i < 512; i++) exp_mem[i] = ref_data[i];

        // Reset in the middle of an encode, then a full fresh encode.
        for (int i = 0; i < 512; i++) ref_data[i] = 8'($urandom);
        start_encode();
        p1 = 0;
        while (cap_idx < 301 && p1 < 1000) begin
            @(posedge clk);
            #1;
            p1++;
        end
        chk("midreset_reached_byte300", 32'(cap_idx >= 301), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_idle("midreset");
        exp_q.delete();
        stat_q.delete();
        reset = 1'b0;
        start_encode();
        wait_done("enc_after_reset");

        // Randomized encode/decode pairs.
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < 512; i++) ref_data[i] = 8'($urandom);
            start_encode();
            wait_done("enc_rand");
            for (int i = 0; i < 528; i++) rx[i] = page[i];
            case ($urandom_range(0, 3))
                0: ;
                1: begin
                    p1 = $urandom_range(0, 511);
                    rx[p1] = rx[p1] ^ 8'($urandom_range(1, 255));
                end
                2: begin
                    p1 = $urandom_range(512, 519);
                    rx[p1] = rx[p1] ^ 8'($urandom_range(1, 255));
                end
                default: begin
                    p1 = $urandom_range(0, 255);
                    p2 = p1 + $urandom_range(1, 255);
                    rx[p1] = rx[p1] ^ 8'($urandom_range(1, 255));
                    rx[p2] = rx[p2] ^ 8'($urandom_range(1, 255));
                end
            endcase
            run_decode("dec_rand");
        end

        repeat (4) @(posedge clk);
        #1;
        chk("flash_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("status_queue_drained", 32'(stat_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ecc_page_ctrl.md
Name:
ecc_page_ctrl

Overview:
NAND-page ECC controller between a 512x8 synchronous page SRAM (sram512x8) and a byte-wide flash data path.
- Encode: streams a 512-byte page from SRAM to flash and appends a 16-byte spare area holding single-symbol-correcting GF(2^8) check bytes.
- Decode: takes a 528-byte page from flash, writes the data to SRAM, then corrects at most one bad byte per 128-byte block in place.

Parameters:
PAGE_BYTES, 512, data bytes per page
SPARE_BYTES, 16, spare bytes appended per page
BLK_BYTES, 128, data bytes per ECC block (4 blocks)
GF_POLY, 9'h11D, GF(2^8) field polynomial; alpha = 8'h02

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse that starts an operation; ignored while busy
encoding  in  1  sampled with start: 1 = encode, 0 = decode
sramDi  out  8  write data to SRAM (D)
sramDo  in  8  SRAM read data (Q), valid the cycle after the address
sramAdrs  out  9  SRAM address
sramEnable  out  1  SRAM CEN, active-low
sramWE  out  1  SRAM WEN, active-low (0 = write)
flashDi  out  8  byte to flash
flashDataValid  out  1  flashDi qualifier
flashDo  in  8  byte from flash
status  out  4  [0] busy, [1] done, [2] corrected, [3] uncorrectable

Behaviour:
- Reset values: sramEnable=1, sramWE=1, sramAdrs=0, sramDi=0, flashDi=0, flashDataValid=0, status=0. FSM goes to IDLE. Reset aborts any operation.
- FSM states: IDLE, ENC_DATA, ENC_SPARE, DEC_RX, DEC_SEARCH, DEC_RD, DEC_WR, DONE.
- start in IDLE or DONE: clears the C0/C1 accumulators and status[3:1], sets busy.
- Per-block check bytes, with d_i = block byte i (i = 0..127):
  - C0 = XOR of all d_i.
  - C1 via Horner: C1 <= mul_alpha(C1) ^ d_i, so C1 = sum d_i*alpha^(127-i).
  - mul_alpha(x) = {x[6:0],0} ^ (x[7] ? 8'h1D : 0).
- Encode:
  - Reads SRAM addresses 0..511, one per cycle.
  - flashDataValid is first high 2 cycles after the start cycle and stays high for 528 consecutive cycles.
  - Bytes 0..511 are the SRAM data.
  - Bytes 512..519 are C0,C1 of block 0, C0,C1 of block 1, ... block 3.
  - Bytes 520..527 are 8'hFF.
- Decode input timing: the byte on flashDo at the k-th rising edge after the start edge (k = 1..528) is page byte k-1.
- DEC_RX:
  - Data bytes 0..511 are written to SRAM at the same address (CEN=0, WEN=0) and accumulated into C0/C1 per block.
  - Received spare bytes give S0 = C0 ^ stored C0 and S1 = C1 ^ stored C1 for each block.
  - Bytes 520..527 are ignored.
- Per-block classification, blocks 0..3 in order:
  - S0=0 and S1=0: clean.
  - Exactly one of S0, S1 is zero: spare-byte error. Set corrected; no SRAM write.
  - Both nonzero: DEC_SEARCH. Set t=S0, then for k = 0..127: if t==S1 the location is j=127-k, else t<=mul_alpha(t). One k per cycle.
  - Match found: DEC_RD reads address blk*128+j; DEC_WR writes Q^S0 there; set corrected.
  - No match after 128 steps: set uncorrectable; block left as received.
- When all blocks are handled: DONE with busy=0, done=1. Flags hold until the next start or reset.
- Outside active accesses, sramEnable=1 and sramWE=1. flashDataValid is 0 in decode.

Decomposition:
- Package ecc_pkg holds PAGE_BYTES, SPARE_BYTES, BLK_BYTES, GF_POLY, the FSM state enum, the status bit indices and a mul_alpha function.
- One natural sub-module, ecc_blk_accum: the C0/C1 Horner accumulator with clear and enable.
- sram512x8 is a separate, existing model.

Test Plan:
- Encode with SRAM[i] = i[7:0] for i<256 and ~i[7:0] otherwise, then start with encoding=1 → 528 contiguous valid bytes; bytes 0..511 match SRAM; bytes 512,514,516,518 (C0) = 8'h00; bytes 520..527 = 8'hFF; done=1.
- Decode the unmodified encoded page → SRAM equals the original; corrected=0, uncorrectable=0.
- Decode with byte 171 forced to 8'h00 (was 8'hAB) → block 1, j=43, S0=8'hAB; SRAM[171]=8'hAB afterwards; corrected=1.
- Decode with bytes 10 and 20 both corrupted → uncorrectable=1; SRAM[10] and SRAM[20] hold the corrupted values.
- Decode with only spare byte 512 corrupted → corrected=1; all 512 SRAM bytes unchanged.
- Assert reset mid-encode at byte 300 → the next cycle has flashDataValid=0, status=0, FSM in IDLE; a fresh encode then completes normally.
